mem_access_sched: RTL and testbench

Sequencer for the PE memory access stage. Accepts nonzero input activations (index, value) from the activation queue, and for each one issues one weight SRAM read per output activation of the current layer. Each issue drives the computation-enable, activation value and output address into the memory stage alongside the weight memory controls. The block sits between the sparse activation queue and the memory access pipeline stage.

---
 rtl/mem_access_sched_pkg.sv | 16 +
 rtl/mem_access_sched.sv | 130 +++++++++++++
 tb/tb_mem_access_sched.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sched_pkg.sv
// rtl/mem_access_sched_pkg.sv - shared widths and state encoding for the PE memory access sequencer
package mem_access_sched_pkg;

  localparam int PE_IN_IDX_W = 8;
  localparam int PE_DATA_W   = 16;
  localparam int PE_ACT_NO_W = 4;
  localparam int W_MEM_ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/mem_access_sched.sv
// rtl/mem_access_sched.sv - issues one weight SRAM read per output activation for each accepted input activation
module mem_access_sched
  import mem_access_sched_pkg::*;
#(
  parameter int IN_IDX_WIDTH = PE_IN_IDX_W,
  parameter int DATA_WIDTH   = PE_DATA_W,
  parameter int ACT_NO_WIDTH = PE_ACT_NO_W,
  parameter int W_ADDR_WIDTH = W_MEM_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ACT_NO_WIDTH-1:0] cfg_num_out,
  input  logic [W_ADDR_WIDTH-1:0] cfg_w_base,
  input  logic                    in_act_valid,
  output logic                    in_act_ready,
  input  logic [IN_IDX_WIDTH-1:0] in_act_idx,
  input  logic [DATA_WIDTH-1:0]   in_act_value,
  input  logic                    in_act_last,
  input  logic                    stall,
  output logic                    comp_en_mem,
  output logic [DATA_WIDTH-1:0]   in_act_value_mem,
  output logic [ACT_NO_WIDTH-1:0] out_act_addr_mem,
  output logic                    w_mem_cen,
  output logic                    w_mem_wen,
  output logic [W_ADDR_WIDTH-1:0] w_mem_addr,
  output logic                    done
);

  localparam int PROD_WIDTH = IN_IDX_WIDTH + ACT_NO_WIDTH + 1;

  sched_state_e            state_q, state_d;
  logic [ACT_NO_WIDTH-1:0] num_out_q, num_out_d;
  logic [W_ADDR_WIDTH-1:0] base_q, base_d;
  logic [W_ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [DATA_WIDTH-1:0]   value_q, value_d;
  logic                    last_q, last_d;
  logic [ACT_NO_WIDTH-1:0] out_cnt_q, out_cnt_d;

  logic                    issue;
  logic                    final_issue;
  logic                    accept;
  logic [ACT_NO_WIDTH:0]   row_len;
  logic [PROD_WIDTH-1:0]   row_prod;
  logic [W_ADDR_WIDTH-1:0] row_base_new;

  // Row base of an incoming activation; the product is truncated so the add wraps.
  assign row_len      = {1'b0, num_out_q} + {{ACT_NO_WIDTH{1'b0}}, 1'b1};
  assign row_prod     = PROD_WIDTH'(in_act_idx) * PROD_WIDTH'(row_len);
  assign row_base_new = base_q + W_ADDR_WIDTH'(row_prod);

  always_comb begin
    state_d      = state_q;
    num_out_d    = num_out_q;
    base_d       = base_q;
    row_base_d   = row_base_q;
    value_d      = value_q;
    last_d       = last_q;
    out_cnt_d    = out_cnt_q;
    issue        = 1'b0;
    final_issue  = 1'b0;
    in_act_ready = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_out_d = cfg_num_out;
          base_d    = cfg_w_base;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        in_act_ready = 1'b1;
      end
      ST_RUN: begin
        issue        = !stall;
        final_issue  = issue && (out_cnt_q == num_out_q);
        in_act_ready = final_issue && !last_q;
        if (final_issue) begin
          out_cnt_d = '0;
          state_d   = last_q ? ST_DONE : ST_WAIT;
        end else if (issue) begin
          out_cnt_d = out_cnt_q + ACT_NO_WIDTH'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    accept = in_act_valid && in_act_ready;
    // An accept in RUN overrides the WAIT/DONE exit so the next row starts without a bubble.
    if (accept) begin
      row_base_d = row_base_new;
      value_d    = in_act_value;
      last_d     = in_act_last;
      out_cnt_d  = '0;
      state_d    = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_out_q  <= '0;
      base_q     <= '0;
      row_base_q <= '0;
      value_q    <= '0;
      last_q     <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      num_out_q  <= num_out_d;
      base_q     <= base_d;
      row_base_q <= row_base_d;
      value_q    <= value_d;
      last_q     <= last_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign comp_en_mem      = issue;
  assign w_mem_cen        = !issue;
  assign w_mem_wen        = 1'b1;
  assign w_mem_addr       = row_base_q + W_ADDR_WIDTH'(out_cnt_q);
  assign in_act_value_mem = issue ? value_q : '0;
  assign out_act_addr_mem = issue ? out_cnt_q : '0;

endmodule

// File: tb/tb_mem_access_sched.sv
// tb/tb_mem_access_sched.sv - scoreboard bench for mem_access_sched with randomized layers
module tb_mem_access_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cfg_num_out;
  logic [11:0] cfg_w_base;
  logic        in_act_valid;
  logic        in_act_ready;
  logic [7:0]  in_act_idx;
  logic [15:0] in_act_value;
  logic        in_act_last;
  logic        stall;
  logic        comp_en_mem;
  logic [15:0] in_act_value_mem;
  logic [3:0]  out_act_addr_mem;
  logic        w_mem_cen;
  logic        w_mem_wen;
  logic [11:0] w_mem_addr;
  logic        done;

  mem_access_sched dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_out(cfg_num_out), .cfg_w_base(cfg_w_base),
    .in_act_valid(in_act_valid), .in_act_ready(in_act_ready), .in_act_idx(in_act_idx),
    .in_act_value(in_act_value), .in_act_last(in_act_last), .stall(stall),
    .comp_en_mem(comp_en_mem), .in_act_value_mem(in_act_value_mem),
    .out_act_addr_mem(out_act_addr_mem), .w_mem_cen(w_mem_cen), .w_mem_wen(w_mem_wen),
    .w_mem_addr(w_mem_addr), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int oaddr;
    int value;
    bit layer_last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   q_idx[$];
  int   q_val[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit exp_done_next = 1'b0;
  int layer_issues  = 0;
  int first_issue_cyc = -1;
  int last_issue_cyc  = -1;
  int stall_mode  = 0;
  bit stall_force = 1'b0;
  bit scripted_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle either an issue popped from the scoreboard or an idle bus.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("w_mem_wen", w_mem_wen, 1);
      if (exp_done_next) begin
        chk("done_pulse", done, 1);
        exp_done_next = 1'b0;
      end else if (done) begin
        chk("unexpected_done", done, 0);
      end
      if (comp_en_mem) begin
        if (sb.size() == 0) begin
          chk("issue_without_expect", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("w_mem_addr", w_mem_addr, mon_e.addr);
          chk("out_act_addr", out_act_addr_mem, mon_e.oaddr);
          chk("act_value", in_act_value_mem, mon_e.value);
          chk("cen_on_issue", w_mem_cen, 0);
          if (mon_e.layer_last) exp_done_next = 1'b1;
        end
        layer_issues++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
      end else begin
        chk("cen_idle", w_mem_cen, 1);
        chk("value_idle", in_act_value_mem, 0);
        chk("oaddr_idle", out_act_addr_mem, 0);
      end
    end
  end

  // Stall generator: off, random, or a scripted two-cycle hold after the second issue.
  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (stall_force) begin
        stall = 1'b1;
      end else if (stall_mode == 1) begin
        stall = ($urandom_range(99) < 25);
      end else if (stall_mode == 2 && !scripted_done && layer_issues == 2) begin
        stall = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        stall = 1'b0;
        scripted_done = 1'b1;
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic send_act(input int idx, input int val, input bit last, input int n,
                          input int base, output int acc_cyc, output bit ok);
    bit acc = 1'b0;
    int budget = 0;
    in_act_valid = 1'b1;
    in_act_idx   = 8'(idx);
    in_act_value = 16'(val);
    in_act_last  = last;
    acc_cyc = -1;
    ok = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (in_act_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        for (int k = 0; k <= n; k++)
          sb.push_back('{(base + idx * (n + 1) + k) % 4096, k, val, last && (k == n)});
      end
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 300) begin
        chk("accept_timeout", 0, 1);
        ok = 1'b0;
        acc = 1'b1;
      end
    end
    in_act_valid = 1'b0;
  endtask

  task automatic do_layer(input int n, input int base, input int valid_pct,
                          input bit spurious, input bit chk_lat, input bit chk_nobubble);
    int acc_cyc;
    int first_acc = -1;
    bit ok;
    bit got = 1'b0;
    layer_issues = 0;
    first_issue_cyc = -1;
    last_issue_cyc = -1;
    start = 1'b1;
    cfg_num_out = 4'(n);
    cfg_w_base = 12'(base);
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_num_out = 4'($urandom);
    cfg_w_base = 12'($urandom);
    for (int a = 0; a < q_idx.size(); a++) begin
      while (valid_pct < 100 && $urandom_range(99) >= valid_pct) begin
        @(posedge clk);
        #1;
      end
      send_act(q_idx[a], q_val[a], a == q_idx.size() - 1, n, base, acc_cyc, ok);
      if (!ok) return;
      if (a == 0) first_acc = acc_cyc;
      if (a == 0 && spurious) begin
        start = 1'b1;
        cfg_num_out = 4'(n ^ 5);
        cfg_w_base = 12'(base ^ 12'h5A5);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    chk("sb_drained", sb.size(), 0);
    chk("issue_count", layer_issues, q_idx.size() * (n + 1));
    if (chk_lat) chk("first_issue_latency", first_issue_cyc, first_acc + 1);
    if (chk_nobubble) chk("no_bubble", last_issue_cyc - first_issue_cyc + 1, layer_issues);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_cyc;
    bit ok;
    int n;
    int na;
    rst = 1'b1;
    start = 1'b0;
    cfg_num_out = '0;
    cfg_w_base = '0;
    in_act_valid = 1'b0;
    in_act_idx = '0;
    in_act_value = '0;
    in_act_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_comp_en", comp_en_mem, 0);
    chk("rst_cen", w_mem_cen, 1);
    chk("rst_wen", w_mem_wen, 1);
    chk("rst_addr", w_mem_addr, 0);
    chk("rst_value", in_act_value_mem, 0);
    chk("rst_oaddr", out_act_addr_mem, 0);
    chk("rst_ready", in_act_ready, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    q_idx = {2};       q_val = {16'h0A5A};
    do_layer(3, 12'h100, 100, 1'b0, 1'b1, 1'b1);

    q_idx = {1, 5};    q_val = {16'h1111, 16'h2222};
    do_layer(1, 0, 100, 1'b0, 1'b1, 1'b1);

    stall_mode = 2;
    scripted_done = 1'b0;
    q_idx = {7};       q_val = {16'hBEEF};
    do_layer(3, 12'h020, 100, 1'b0, 1'b1, 1'b0);
    chk("scripted_stall_applied", scripted_done, 1);
    stall_mode = 0;

    q_idx = {1};       q_val = {16'h0F0F};
    do_layer(0, 12'hFFF, 100, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a row: hold issue with stall, then pulse rst.
    layer_issues = 0;
    start = 1'b1;
    cfg_num_out = 4'd3;
    cfg_w_base = 12'h040;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_act(3, 16'h1234, 1'b1, 3, 12'h040, acc_cyc, ok);
    for (int i = 0; i < 50 && layer_issues < 2; i++) @(negedge clk);
    chk("reached_two_issues", layer_issues, 2);
    @(posedge clk);
    #1;
    stall_force = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall_force = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_comp_en", comp_en_mem, 0);
    chk("mid_rst_cen", w_mem_cen, 1);
    chk("mid_rst_addr", w_mem_addr, 0);
    chk("mid_rst_value", in_act_value_mem, 0);
    chk("mid_rst_oaddr", out_act_addr_mem, 0);
    chk("mid_rst_ready", in_act_ready, 0);
    chk("mid_rst_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_low", in_act_ready, 0);
    end
    @(posedge clk);
    #1;
    q_idx = {9};       q_val = {16'h5555};
    do_layer(3, 12'h040, 100, 1'b0, 1'b1, 1'b1);

    q_idx = {4, 7};    q_val = {16'hA1A1, 16'hB2B2};
    do_layer(2, 12'h200, 100, 1'b1, 1'b1, 1'b0);

    stall_mode = 1;
    for (int l = 0; l < 20; l++) begin
      n = $urandom_range(15);
      na = $urandom_range(4, 1);
      q_idx.delete();
      q_val.delete();
      for (int a = 0; a < na; a++) begin
        q_idx.push_back($urandom_range(255));
        q_val.push_back($urandom_range(16'hFFFF));
      end
      do_layer(n, $urandom_range(12'hFFF), 60, l % 4 == 0, 1'b0, 1'b0);
    end
    stall_mode = 0;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
